mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Initiator side of the CPU data-memory interface. Takes one load/store request at a time from the
//  execute stage and drives the byte-addressed RAM port (addr / write_en / write_data / read_data).
//  Supports word and byte loads and stores. A byte store is done as a read-modify-write of the word at
//  the byte's address. Out-of-range accesses are checked before any memory cycle and are reported as faults.
// PARAMETERS
//  MEM_BYTES  800  size of the attached RAM in bytes; an access is legal iff req_addr <= MEM_BYTES-4
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   synchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit can accept a request (IDLE only)
//  req_write       in   1   1 = store, 0 = load
//  req_byte        in   1   1 = byte access (bits [7:0]), 0 = 32-bit word
//  req_addr        in   32  byte address; no alignment requirement
//  req_wdata       in   32  store data; byte store uses [7:0]
//  resp_valid      out  1   one-cycle pulse: request complete
//  resp_rdata      out  32  load data: word, or {24'b0,byte}; 0 for stores and faults
//  resp_fault      out  1   valid with resp_valid: address out of range, no memory write issued
//  mem_address     out  32  RAM address
//  mem_write_en    out  1   RAM write strobe; RAM writes 4 bytes little-endian at posedge
//  mem_write_data  out  32  RAM write data
//  mem_read_data   in   32  RAM combinational read of {m[a+3],m[a+2],m[a+1],m[a]}
// BEHAVIOUR
//  - Reset: state=IDLE. req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_address=0,
//    mem_write_en=0, mem_write_data=0. Reset takes priority over everything, including an in-flight request.
//  - States: IDLE, RD, RMW_RD, WR, RESP.
//  - IDLE: req_ready=1. When req_valid=1, latch write/byte/addr/wdata and set mem_address=req_addr.
//    Range check: req_addr > MEM_BYTES-4 -> go to RESP with fault=1 and rdata=0.
//    Otherwise go to: RD (load), WR (word store; mem_write_data=req_wdata), or RMW_RD (byte store).
//  - RD: capture mem_read_data at the end of the cycle. rdata = word, or {24'b0, rd[7:0]} if byte. Go to RESP.
//  - RMW_RD: set mem_write_data={mem_read_data[31:8], wdata[7:0]}. Go to WR.
//  - WR: mem_write_en=1 for exactly this cycle. Go to RESP with rdata=0.
//  - mem_write_en = (state==WR) && !reset. A write is never issued in a cycle where reset is high.
//  - RESP: resp_valid=1 for one cycle, req_ready=0. Then go to IDLE. resp_rdata/resp_fault hold until
//    the next RESP.
//  - Latency, counted from the accept edge to the resp_valid cycle:
//    fault = 1 cycle; word load / word store = 2 cycles; byte store = 3 cycles.
//  - req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored, with no queueing.
//  - mem_address is stable from the accept edge through RESP. No change mid-access.
//  - Boundary: addr MEM_BYTES-4 is legal; MEM_BYTES-3 and above fault, including a byte access at
//    MEM_BYTES-1. The compare is unsigned 32-bit, so 0xFFFFFFFF faults and there is no wrap-around.
//  - Byte store RMW is not atomic with respect to other initiators. This unit is the only RAM writer.
// TESTING  (MEM_BYTES=800; RAM reset image: word@0 = 0xE3A00005, words from 24 up = 0xE1A00000)
//  1. Word load addr 0 -> resp_valid 2 cycles after accept, rdata=0xE3A00005, fault=0.
//     Byte load addr 0 -> 0x00000005; byte load addr 3 -> 0x000000E3.
//  2. Word store 0x12345678 @100, then word load @100 -> 0x12345678.
//     Check mem_write_en is high for exactly 1 cycle.
//  3. After test 2: byte store 0xAB @101 (3-cycle latency), then word load @100 -> 0x1234AB78,
//     and word load @104 unchanged.
//  4. Word store @797 -> resp_fault=1 one cycle after accept, mem_write_en never asserted.
//     Word load @796 -> fault=0, rdata=0xE1A00000.
//  5. Assert reset in the WR cycle of a word store @200 -> mem_write_en stays 0, no resp_valid,
//     next cycle req_ready=1. A following load @200 returns the RAM reset contents.
//  6. Hold req_valid high across back-to-back requests -> each is accepted only in IDLE,
//     exactly one resp_valid per accepted request, never two in consecutive cycles.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the CPU data-memory interface.
// Accepts one load/store at a time and sequences the RAM port. A byte store is
// a read-modify-write of the word at the byte's address. Out-of-range addresses
// are rejected before any memory cycle is started.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // Highest start address whose full 4-byte window still lies inside the RAM.
    localparam logic [31:0] LAST_LEGAL = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        lat_byte;
    logic        lat_byte_next;
    logic [7:0]  lat_wbyte;
    logic [7:0]  lat_wbyte_next;
    logic [31:0] mem_address_next;
    logic [31:0] mem_write_data_next;
    logic [31:0] resp_rdata_next;
    logic        resp_fault_next;

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lat_byte       <= 1'b0;
            lat_wbyte      <= 8'h00;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
            resp_rdata     <= 32'h0;
            resp_fault     <= 1'b0;
        end else begin
            state          <= state_next;
            lat_byte       <= lat_byte_next;
            lat_wbyte      <= lat_wbyte_next;
            mem_address    <= mem_address_next;
            mem_write_data <= mem_write_data_next;
            resp_rdata     <= resp_rdata_next;
            resp_fault     <= resp_fault_next;
        end
    end

    // Next-state and next-datapath logic; everything holds unless a state updates it.
    always_comb begin
        state_next          = state;
        lat_byte_next       = lat_byte;
        lat_wbyte_next      = lat_wbyte;
        mem_address_next    = mem_address;
        mem_write_data_next = mem_write_data;
        resp_rdata_next     = resp_rdata;
        resp_fault_next     = resp_fault;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    mem_address_next = req_addr;
                    lat_byte_next    = req_byte;
                    lat_wbyte_next   = req_wdata[7:0];
                    if (req_addr > LAST_LEGAL) begin
                        resp_fault_next = 1'b1;
                        resp_rdata_next = 32'h0;
                        state_next      = RESP;
                    end else if (!req_write) begin
                        state_next = RD;
                    end else if (!req_byte) begin
                        mem_write_data_next = req_wdata;
                        state_next          = WR;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end

            RD: begin
                resp_rdata_next = lat_byte ? {24'h0, mem_read_data[7:0]} : mem_read_data;
                resp_fault_next = 1'b0;
                state_next      = RESP;
            end

            RMW_RD: begin
                mem_write_data_next = {mem_read_data[31:8], lat_wbyte};
                state_next          = WR;
            end

            WR: begin
                resp_rdata_next = 32'h0;
                resp_fault_next = 1'b0;
                state_next      = RESP;
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and write strobe; the strobe is masked by reset so an aborted
    // store never reaches the RAM.
    always_comb begin
        req_ready    = (state == IDLE);
        resp_valid   = (state == RESP);
        mem_write_en = (state == WR) && !reset;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural 800-byte RAM.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 800;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [7:0]  ram [0:MEM_BYTES-1];
    logic        ram_load;

    int n_compared;
    int n_mismatched;
    int we_count;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: loads its reset image while ram_load is high, otherwise takes little-endian word writes.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) begin
                ram[i] <= (i >= 24) ? ((i % 4 == 2) ? 8'hA0 : (i % 4 == 3) ? 8'hE1 : 8'h00) : 8'h00;
            end
            ram[0] <= 8'h05;
            ram[1] <= 8'h00;
            ram[2] <= 8'hA0;
            ram[3] <= 8'hE3;
        end else if (mem_write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_address + 32'(k) < 32'(MEM_BYTES)) begin
                    ram[10'(mem_address + 32'(k))] <= mem_write_data[8*k +: 8];
                end
            end
        end
    end

    // RAM combinational read; bytes outside the array read as zero.
    always_comb begin
        logic [31:0] ba;
        mem_read_data = 32'h0;
        ba = 32'h0;
        for (int k = 0; k < 4; k++) begin
            ba = mem_address + 32'(k);
            if (ba < 32'(MEM_BYTES)) begin
                mem_read_data[8*k +: 8] = ram[ba[9:0]];
            end
        end
    end

    // Count every cycle in which the write strobe is high.
    always @(negedge clk) begin
        if (mem_write_en === 1'b1) we_count++;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request from a negedge, return latency, write-strobe cycles and
    // whether mem_address stayed on the request address. Returns at the RESP negedge.
    task automatic apply_stimulus(input logic wr, input logic bt, input logic [31:0] addr,
                                  input logic [31:0] wdata, output int latency,
                                  output int writes, output logic addr_ok);
        int guard;
        int w0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
        w0 = we_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        latency = 1;
        addr_ok = (mem_address === addr);
        while (resp_valid !== 1'b1 && latency < 10) begin
            @(posedge clk);
            #1;
            latency++;
            if (mem_address !== addr) addr_ok = 1'b0;
        end
        @(negedge clk);
        writes = we_count - w0;
    endtask

    int   lat;
    int   wrs;
    logic aok;
    int   accepts;
    int   resps;
    int   consec;
    logic prev_resp;
    int   w_snap;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        we_count     = 0;
        reset        = 1'b1;
        ram_load     = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_byte     = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        ram_load = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_req_ready", 32'(req_ready), 32'd1);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_resp_fault", 32'(resp_fault), 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'h0);
        check_output("rst_mem_address", mem_address, 32'h0);
        check_output("rst_mem_write_en", 32'(mem_write_en), 32'd0);
        check_output("rst_mem_write_data", mem_write_data, 32'h0);

        $display("[TB] test 1: loads from reset image");
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'h0, lat, wrs, aok);
        check_output("t1_word_latency", 32'(lat), 32'd2);
        check_output("t1_word_rdata", resp_rdata, 32'hE3A00005);
        check_output("t1_word_fault", 32'(resp_fault), 32'd0);
        check_output("t1_word_addr_stable", 32'(aok), 32'd1);
        @(negedge clk);
        check_output("t1_rdata_hold", resp_rdata, 32'hE3A00005);
        check_output("t1_resp_valid_pulse", 32'(resp_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1, 32'd0, 32'h0, lat, wrs, aok);
        check_output("t1_byte0_rdata", resp_rdata, 32'h00000005);
        apply_stimulus(1'b0, 1'b1, 32'd3, 32'h0, lat, wrs, aok);
        check_output("t1_byte3_rdata", resp_rdata, 32'h000000E3);

        $display("[TB] test 2: word store then load");
        apply_stimulus(1'b1, 1'b0, 32'd100, 32'h12345678, lat, wrs, aok);
        check_output("t2_store_latency", 32'(lat), 32'd2);
        check_output("t2_store_writes", 32'(wrs), 32'd1);
        check_output("t2_store_rdata", resp_rdata, 32'h0);
        check_output("t2_store_addr_stable", 32'(aok), 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'd100, 32'h0, lat, wrs, aok);
        check_output("t2_load_rdata", resp_rdata, 32'h12345678);
        check_output("t2_load_writes", 32'(wrs), 32'd0);

        $display("[TB] test 3: byte store read-modify-write");
        apply_stimulus(1'b1, 1'b1, 32'd101, 32'hFFFFFFAB, lat, wrs, aok);
        check_output("t3_bstore_latency", 32'(lat), 32'd3);
        check_output("t3_bstore_writes", 32'(wrs), 32'd1);
        check_output("t3_bstore_addr_stable", 32'(aok), 32'd1);
        apply_stimulus(1'b0, 1'b0, 32'd100, 32'h0, lat, wrs, aok);
        check_output("t3_load100", resp_rdata, 32'h1234AB78);
        apply_stimulus(1'b0, 1'b0, 32'd104, 32'h0, lat, wrs, aok);
        check_output("t3_load104", resp_rdata, 32'hE1A00000);

        $display("[TB] test 4: range boundary");
        apply_stimulus(1'b1, 1'b0, 32'd797, 32'hCAFEF00D, lat, wrs, aok);
        check_output("t4_797_latency", 32'(lat), 32'd1);
        check_output("t4_797_fault", 32'(resp_fault), 32'd1);
        check_output("t4_797_writes", 32'(wrs), 32'd0);
        check_output("t4_797_rdata", resp_rdata, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'd796, 32'h0, lat, wrs, aok);
        check_output("t4_796_fault", 32'(resp_fault), 32'd0);
        check_output("t4_796_rdata", resp_rdata, 32'hE1A00000);
        apply_stimulus(1'b0, 1'b1, 32'd799, 32'h0, lat, wrs, aok);
        check_output("t4_799_byte_fault", 32'(resp_fault), 32'd1);
        check_output("t4_799_byte_rdata", resp_rdata, 32'h0);
        apply_stimulus(1'b1, 1'b1, 32'hFFFFFFFF, 32'h55, lat, wrs, aok);
        check_output("t4_ffff_fault", 32'(resp_fault), 32'd1);
        check_output("t4_ffff_writes", 32'(wrs), 32'd0);

        $display("[TB] test 5: reset during write cycle");
        while (req_ready !== 1'b1) @(negedge clk);
        w_snap    = we_count;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'd200;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check_output("t5_we_in_reset", 32'(mem_write_en), 32'd0);
        @(negedge clk);
        check_output("t5_we_in_reset_neg", 32'(mem_write_en), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("t5_ready_after", 32'(req_ready), 32'd1);
        check_output("t5_no_resp", 32'(resp_valid), 32'd0);
        check_output("t5_no_write", 32'(we_count - w_snap), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd200, 32'h0, lat, wrs, aok);
        check_output("t5_load200", resp_rdata, 32'hE1A00000);

        $display("[TB] test 6: back-to-back requests");
        while (req_ready !== 1'b1) @(negedge clk);
        accepts   = 0;
        resps     = 0;
        consec    = 0;
        prev_resp = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'd0;
        for (int c = 0; c < 21; c++) begin
            if (req_valid === 1'b1 && req_ready === 1'b1) accepts++;
            if (resp_valid === 1'b1) begin
                resps++;
                if (prev_resp) consec++;
            end
            prev_resp = resp_valid;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check_output("t6_accepts", 32'(accepts), 32'd7);
        check_output("t6_resps", 32'(resps), 32'd7);
        check_output("t6_consecutive", 32'(consec), 32'd0);
        check_output("t6_ready_idle", 32'(req_ready), 32'd1);
        check_output("t6_rdata", resp_rdata, 32'hE3A00005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
